// File: rtl/streaming_inverse_chunk_transposer.sv
// Double-buffered cell-to-row transposer: collects CHUNK_SIZE cells per bank, then emits CELL_SIZE video rows.
// Optional counters (chunk_count, stall_count) are enabled by defining INV_CHUNK_TRANSPOSER_STATS_EN.
module streaming_inverse_chunk_transposer #(
  parameter int CELL_SIZE  = 2,
  parameter int CHUNK_SIZE = 64,
  parameter int PIXEL_W    = 8
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      s_valid,
  output logic                                      s_ready,
  input  logic [CELL_SIZE*CELL_SIZE*PIXEL_W-1:0]    s_cell,
  output logic                                      m_valid,
  input  logic                                      m_ready,
  output logic [CHUNK_SIZE*CELL_SIZE*PIXEL_W-1:0]   m_row,
  output logic                                      m_last,
  output logic [$clog2(CELL_SIZE)-1:0]              m_row_idx
`ifdef INV_CHUNK_TRANSPOSER_STATS_EN
  ,
  output logic [31:0]                               chunk_count,
  output logic [31:0]                               stall_count
`endif
);

  localparam int CW = $clog2(CHUNK_SIZE);
  localparam int RW = $clog2(CELL_SIZE);
  localparam logic [CW-1:0] WR_LAST = CW'(CHUNK_SIZE - 1);
  localparam logic [RW-1:0] RD_LAST = RW'(CELL_SIZE - 1);

  // bank[b][cell j][row i][col k]
  logic [PIXEL_W-1:0] bank [2][CHUNK_SIZE][CELL_SIZE][CELL_SIZE];

  logic          wr_sel;
  logic          rd_sel;
  logic [CW-1:0] wr_cnt;
  logic [RW-1:0] rd_row;
  logic [1:0]    full;
  logic          wr_hs;
  logic          rd_hs;

  assign s_ready   = !full[wr_sel];
  assign m_valid   = full[rd_sel];
  assign m_last    = (rd_row == RD_LAST);
  assign m_row_idx = rd_row;
  assign wr_hs     = s_valid && s_ready;
  assign rd_hs     = m_valid && m_ready;

  // A write can only target a non-full bank and a read only a full one, so the
  // set and clear below always land on different bits of full.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_sel <= 1'b0;
      rd_sel <= 1'b0;
      wr_cnt <= '0;
      rd_row <= '0;
      full   <= '0;
    end else begin
      if (wr_hs) begin
        if (wr_cnt == WR_LAST) begin
          wr_cnt       <= '0;
          full[wr_sel] <= 1'b1;
          wr_sel       <= !wr_sel;
        end else begin
          wr_cnt <= wr_cnt + 1'b1;
        end
      end
      if (rd_hs) begin
        if (m_last) begin
          rd_row       <= '0;
          full[rd_sel] <= 1'b0;
          rd_sel       <= !rd_sel;
        end else begin
          rd_row <= rd_row + 1'b1;
        end
      end
    end
  end

  // NOTE: the pixel store has no reset; the full bits alone decide what is visible.
  always_ff @(posedge clk) begin
    if (wr_hs && !reset) begin
      for (int i = 0; i < CELL_SIZE; i++) begin
        for (int k = 0; k < CELL_SIZE; k++) begin
          bank[wr_sel][wr_cnt][i][k] <= s_cell[(i*CELL_SIZE + k)*PIXEL_W +: PIXEL_W];
        end
      end
    end
  end

  // NOTE: default assigned first so the read mux can never infer a latch.
  always_comb begin
    m_row = '0;
    for (int j = 0; j < CHUNK_SIZE; j++) begin
      for (int k = 0; k < CELL_SIZE; k++) begin
        m_row[(j*CELL_SIZE + k)*PIXEL_W +: PIXEL_W] = bank[rd_sel][j][rd_row][k];
      end
    end
  end

`ifdef INV_CHUNK_TRANSPOSER_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      chunk_count <= '0;
      stall_count <= '0;
    end else begin
      if (rd_hs && m_last)     chunk_count <= chunk_count + 32'd1;
      if (s_valid && !s_ready) stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_streaming_inverse_chunk_transposer.sv
// Scoreboard bench for streaming_inverse_chunk_transposer (CELL_SIZE=2, CHUNK_SIZE=4, 12-bit pixels).
// A negedge monitor turns accepted cells into expected rows and checks every presented row.
module tb_streaming_inverse_chunk_transposer;

  localparam int CS        = 2;
  localparam int CH        = 4;
  localparam int PW        = 12;
  localparam int RW        = $clog2(CS);
  localparam int CELL_BITS = CS*CS*PW;
  localparam int ROW_BITS  = CH*CS*PW;

  typedef struct {
    logic [ROW_BITS-1:0] row;
    logic                last;
    logic [RW-1:0]       idx;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 s_valid;
  logic                 s_ready;
  logic [CELL_BITS-1:0] s_cell;
  logic                 m_valid;
  logic                 m_ready;
  logic [ROW_BITS-1:0]  m_row;
  logic                 m_last;
  logic [RW-1:0]        m_row_idx;
`ifdef INV_CHUNK_TRANSPOSER_STATS_EN
  logic [31:0]          chunk_count;
  logic [31:0]          stall_count;
`endif

  streaming_inverse_chunk_transposer #(
    .CELL_SIZE(CS), .CHUNK_SIZE(CH), .PIXEL_W(PW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_cell    (s_cell),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_row     (m_row),
    .m_last    (m_last),
    .m_row_idx (m_row_idx)
`ifdef INV_CHUNK_TRANSPOSER_STATS_EN
    ,
    .chunk_count(chunk_count),
    .stall_count(stall_count)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [ROW_BITS-1:0] act,
                       input logic [ROW_BITS-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model + monitor ----------------
  exp_t                 sb[$];
  logic [CELL_BITS-1:0] cur[$];
  int                   rows_seen = 0;
  int                   chunk_m = 0;
  int                   stall_m = 0;
  logic                 stall_pend = 1'b0;
  logic [ROW_BITS-1:0]  held_row;
  logic                 held_last;
  logic [RW-1:0]        held_idx;

  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
      cur.delete();
      stall_pend = 1'b0;
      chunk_m    = 0;
      stall_m    = 0;
    end else begin
      // Banks still holding unread rows; both occupied means no room for input.
      int pending;
      pending = (sb.size() + CS - 1) / CS;
      check("s_ready", ROW_BITS'(s_ready), ROW_BITS'(pending < 2));
      check("m_valid", ROW_BITS'(m_valid), ROW_BITS'(sb.size() != 0));
      if (stall_pend) begin
        check("stall_row",  m_row, held_row);
        check("stall_last", ROW_BITS'(m_last), ROW_BITS'(held_last));
        check("stall_idx",  ROW_BITS'(m_row_idx), ROW_BITS'(held_idx));
      end
      if (m_valid && m_ready && sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        rows_seen++;
        check("row_data", m_row, e.row);
        check("row_last", ROW_BITS'(m_last), ROW_BITS'(e.last));
        check("row_idx",  ROW_BITS'(m_row_idx), ROW_BITS'(e.idx));
        if (e.last) chunk_m++;
      end
      stall_pend = m_valid && !m_ready;
      held_row   = m_row;
      held_last  = m_last;
      held_idx   = m_row_idx;
      if (s_valid && !s_ready) stall_m++;
      if (s_valid && s_ready) begin
        cur.push_back(s_cell);
        if (cur.size() == CH) begin
          for (int i = 0; i < CS; i++) begin
            exp_t e;
            e.row  = '0;
            e.last = (i == CS - 1);
            e.idx  = RW'(i);
            for (int j = 0; j < CH; j++)
              for (int k = 0; k < CS; k++)
                e.row[(j*CS + k)*PW +: PW] = cur[j][(i*CS + k)*PW +: PW];
            sb.push_back(e);
          end
          cur.delete();
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [CELL_BITS-1:0] jik_cell(input int j);
    logic [CELL_BITS-1:0] c;
    c = '0;
    for (int i = 0; i < CS; i++)
      for (int k = 0; k < CS; k++)
        c[(i*CS + k)*PW +: PW] = {4'(i), 4'(j), 4'(k)};
    return c;
  endfunction

  function automatic logic [CELL_BITS-1:0] rand_cell();
    return CELL_BITS'({$urandom, $urandom});
  endfunction

  task automatic send_cell(input logic [CELL_BITS-1:0] c);
    int   n;
    logic rdy;
    n       = 0;
    s_valid = 1'b1;
    s_cell  = c;
    do begin
      @(negedge clk);
      rdy = s_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!rdy && n < 500);
    check("send_timeout", ROW_BITS'(rdy), ROW_BITS'(1));
    s_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n       = 0;
    m_ready = 1'b1;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain", ROW_BITS'(sb.size()), ROW_BITS'(0));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  logic send_done;
  int   rows_before;

  initial begin
    reset   = 1'b1;
    s_valid = 1'b0;
    s_cell  = '0;
    m_ready = 1'b0;
    do_reset();

    // Reset state
    @(negedge clk);
    check("rst_s_ready", ROW_BITS'(s_ready), ROW_BITS'(1));
    check("rst_m_valid", ROW_BITS'(m_valid), ROW_BITS'(0));
    check("rst_m_last",  ROW_BITS'(m_last),  ROW_BITS'(0));
    check("rst_row_idx", ROW_BITS'(m_row_idx), ROW_BITS'(0));
    @(posedge clk);
    #1;

    // One chunk of {i,j,k}-encoded pixels with the sink always ready
    m_ready = 1'b1;
    for (int j = 0; j < CH; j++) send_cell(jik_cell(j));
    drain();

    // Three chunks back-to-back against a blocked sink
    fork
      for (int n = 0; n < 3*CH; n++) send_cell(rand_cell());
      begin
        m_ready = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        m_ready = 1'b1;
      end
    join
    drain();

    // Random sink stalls and source gaps across three chunks
    rows_before = rows_seen;
    send_done   = 1'b0;
    fork
      begin
        for (int n = 0; n < 3*CH; n++) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
          send_cell(rand_cell());
        end
        send_done = 1'b1;
      end
      begin
        int n;
        n = 0;
        while (!(send_done && sb.size() == 0) && n < 1000) begin
          m_ready = 1'($urandom);
          @(posedge clk);
          #1;
          n++;
        end
      end
    join
    drain();
    check("row_handshakes", ROW_BITS'(rows_seen - rows_before), ROW_BITS'(3*CS));

    // Last-row read of chunk A coincides with last-cell write of chunk B
    m_ready = 1'b0;
    for (int n = 0; n < CH; n++) send_cell(rand_cell());
    for (int n = 0; n < CH - 1; n++) send_cell(rand_cell());
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    send_cell(rand_cell());
    @(negedge clk);
    check("simul_m_valid", ROW_BITS'(m_valid), ROW_BITS'(1));
    check("simul_row_idx", ROW_BITS'(m_row_idx), ROW_BITS'(0));
    @(posedge clk);
    #1;
    drain();

    // Reset mid-write, then reset while row 1 is presented
    send_cell(rand_cell());
    send_cell(rand_cell());
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst1_s_ready", ROW_BITS'(s_ready), ROW_BITS'(1));
    check("rst1_m_valid", ROW_BITS'(m_valid), ROW_BITS'(0));
    @(posedge clk);
    #1;
    m_ready = 1'b0;
    for (int n = 0; n < CH; n++) send_cell(rand_cell());
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    m_ready = 1'b0;
    reset   = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst2_s_ready", ROW_BITS'(s_ready), ROW_BITS'(1));
    check("rst2_m_valid", ROW_BITS'(m_valid), ROW_BITS'(0));
    @(posedge clk);
    #1;
    m_ready = 1'b1;
    for (int j = 0; j < CH; j++) send_cell(jik_cell(j));
    drain();

    // Five chunks after a fresh reset, some source stalls included
    do_reset();
    fork
      for (int n = 0; n < 5*CH; n++) send_cell(rand_cell());
      begin
        m_ready = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        m_ready = 1'b1;
      end
    join
    drain();
`ifdef INV_CHUNK_TRANSPOSER_STATS_EN
    check("chunk_count",   ROW_BITS'(chunk_count), ROW_BITS'(5));
    check("chunk_model",   ROW_BITS'(chunk_count), ROW_BITS'(chunk_m));
    check("stall_count",   ROW_BITS'(stall_count), ROW_BITS'(stall_m));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
